// File: rtl/riscv_core_mul_ctrl_if.sv
// Bundle of the request, response and multiplier-side signals of the
// RV64 M-extension multiply sequencer.
interface riscv_core_mul_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) ();

  logic                  i_mulctrl_valid;
  logic                  o_mulctrl_ready;
  logic [1:0]            i_mulctrl_op;
  logic [XLEN-1:0]       i_mulctrl_rs1;
  logic [XLEN-1:0]       i_mulctrl_rs2;
  logic [TAG_W-1:0]      i_mulctrl_tag;
  logic                  i_mulctrl_flush;
  logic                  o_mulctrl_valid;
  logic                  i_mulctrl_ready;
  logic [XLEN-1:0]       o_mulctrl_result;
  logic [TAG_W-1:0]      o_mulctrl_tag;
  logic                  o_mul_en;
  logic [XLEN-1:0]       o_mul_multiplicand;
  logic [XLEN-1:0]       o_mul_multiplier;
  logic                  i_mul_done;
  logic [2*XLEN-1:0]     i_mul_product;

  // Sequencer side
  modport slave (
    input  i_mulctrl_valid, i_mulctrl_op, i_mulctrl_rs1, i_mulctrl_rs2,
           i_mulctrl_tag, i_mulctrl_flush, i_mulctrl_ready,
           i_mul_done, i_mul_product,
    output o_mulctrl_ready, o_mulctrl_valid, o_mulctrl_result, o_mulctrl_tag,
           o_mul_en, o_mul_multiplicand, o_mul_multiplier
  );

  // Pipeline / multiplier side
  modport master (
    output i_mulctrl_valid, i_mulctrl_op, i_mulctrl_rs1, i_mulctrl_rs2,
           i_mulctrl_tag, i_mulctrl_flush, i_mulctrl_ready,
           i_mul_done, i_mul_product,
    input  o_mulctrl_ready, o_mulctrl_valid, o_mulctrl_result, o_mulctrl_tag,
           o_mul_en, o_mul_multiplicand, o_mul_multiplier
  );

endinterface

// File: rtl/riscv_core_mul_ctrl.sv
// Sequencer for MUL/MULH/MULHSU/MULHU in front of the iterative unsigned
// multiplier: takes operand magnitudes, starts the multiplier, restores the
// sign of the 128-bit product and returns the selected half with its tag.
module riscv_core_mul_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input logic                  i_mulctrl_clk,
  input logic                  i_mulctrl_rstn,
  riscv_core_mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  state_e               state_q;
  state_e               state_d;
  mul_op_e              op_q;
  logic                 neg_q;
  logic [TAG_W-1:0]     tag_q;
  logic [XLEN-1:0]      mcand_q;
  logic [XLEN-1:0]      mplier_q;
  logic [XLEN-1:0]      result_q;

  mul_op_e              req_op;
  logic                 rs1_signed;
  logic                 rs2_signed;
  logic                 req_zero;
  logic                 accept;
  logic [XLEN-1:0]      rs1_mag;
  logic [XLEN-1:0]      rs2_mag;
  logic [2*XLEN-1:0]    prod_fix;
  logic [XLEN-1:0]      prod_sel;

  // Request decode: sign flags, magnitudes (|-2^63| wraps to 2^63 unsigned) and zero fast path
  always_comb begin
    req_op     = mul_op_e'(bus.i_mulctrl_op);
    rs1_signed = ((req_op == OP_MULH) || (req_op == OP_MULHSU)) && bus.i_mulctrl_rs1[XLEN-1];
    rs2_signed = (req_op == OP_MULH) && bus.i_mulctrl_rs2[XLEN-1];
    rs1_mag    = rs1_signed ? ({XLEN{1'b0}} - bus.i_mulctrl_rs1) : bus.i_mulctrl_rs1;
    rs2_mag    = rs2_signed ? ({XLEN{1'b0}} - bus.i_mulctrl_rs2) : bus.i_mulctrl_rs2;
    req_zero   = (bus.i_mulctrl_rs1 == '0) || (bus.i_mulctrl_rs2 == '0);
    accept     = (state_q == IDLE) && bus.i_mulctrl_valid && !bus.i_mulctrl_flush;
    prod_fix   = neg_q ? ({(2*XLEN){1'b0}} - bus.i_mul_product) : bus.i_mul_product;
    prod_sel   = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge i_mulctrl_clk) begin
    if (!i_mulctrl_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush coinciding with done discards the product outright
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_zero ? RESP : START;
      START:   state_d = bus.i_mulctrl_flush ? IDLE : BUSY;
      BUSY: begin
        if (bus.i_mulctrl_flush)  state_d = bus.i_mul_done ? IDLE : DRAIN;
        else if (bus.i_mul_done)  state_d = RESP;
      end
      DRAIN:   if (bus.i_mul_done) state_d = IDLE;
      RESP:    if (bus.i_mulctrl_flush || bus.i_mulctrl_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand, tag and result registers; operands stay put until the next accept
  always_ff @(posedge i_mulctrl_clk) begin
    if (!i_mulctrl_rstn) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      tag_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= req_op;
      neg_q    <= rs1_signed ^ rs2_signed;
      tag_q    <= bus.i_mulctrl_tag;
      mcand_q  <= rs1_mag;
      mplier_q <= rs2_mag;
      result_q <= '0;
    end else if ((state_q == BUSY) && bus.i_mul_done && !bus.i_mulctrl_flush) begin
      result_q <= prod_sel;
    end
  end

  // Outputs; everything is forced low while reset is held
  always_comb begin
    bus.o_mulctrl_ready    = (state_q == IDLE) && i_mulctrl_rstn;
    bus.o_mul_en           = (state_q == START) && !bus.i_mulctrl_flush && i_mulctrl_rstn;
    bus.o_mulctrl_valid    = (state_q == RESP) && !bus.i_mulctrl_flush && i_mulctrl_rstn;
    bus.o_mulctrl_result   = result_q;
    bus.o_mulctrl_tag      = tag_q;
    bus.o_mul_multiplicand = mcand_q;
    bus.o_mul_multiplier   = mplier_q;
  end

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Self-checking bench for riscv_core_mul_ctrl with a 64-cycle multiplier model
// and a scoreboard of expected results/tags.
module tb_riscv_core_mul_ctrl;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic            clk;
  logic            rstn;
  int              assert_count;
  int              fail_count;
  int              en_count;
  exp_t            exp_q[$];
  logic            m_busy;
  logic [6:0]      m_cnt;
  logic [XLEN-1:0] m_plier;

  riscv_core_mul_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  riscv_core_mul_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_mulctrl_clk  (clk),
    .i_mulctrl_rstn (rstn),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: samples the multiplier on en, re-reads the multiplicand at done,
  // done is high in the 64th cycle after the en cycle
  always @(posedge clk) begin
    if (!rstn) begin
      m_busy  <= 1'b0;
      m_cnt   <= '0;
      m_plier <= '0;
    end else if (bus.o_mul_en) begin
      m_busy  <= 1'b1;
      m_cnt   <= '0;
      m_plier <= bus.o_mul_multiplier;
    end else if (m_busy) begin
      if (m_cnt == 7'd63) m_busy <= 1'b0;
      m_cnt <= m_cnt + 7'd1;
    end
  end

  assign bus.i_mul_done    = m_busy && (m_cnt == 7'd63);
  assign bus.i_mul_product = (m_busy && (m_cnt == 7'd63)) ?
                             (128'(bus.o_mul_multiplicand) * 128'(m_plier)) : 128'd0;

  // Count multiplier start pulses
  always @(negedge clk) begin
    if (bus.o_mul_en) en_count <= en_count + 1;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required done", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] p;
    ea = ((op == OP_MULH) || (op == OP_MULHSU)) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (op == OP_MULH) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[63:0] : p[127:64];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctrl"}, 128'({bus.o_mulctrl_ready, bus.o_mulctrl_valid,
                                       bus.o_mul_en, bus.o_mulctrl_tag}), 128'd0);
    checkOutput({name, "_result_mcand"}, {bus.o_mulctrl_result, bus.o_mul_multiplicand}, 128'd0);
    checkOutput({name, "_mplier"}, 128'(bus.o_mul_multiplier), 128'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance
  task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] rs1,
                               input logic [XLEN-1:0] rs2, input logic [TAG_W-1:0] tag);
    int   waited;
    logic accepted;
    bus.i_mulctrl_valid = 1'b1;
    bus.i_mulctrl_op    = op;
    bus.i_mulctrl_rs1   = rs1;
    bus.i_mulctrl_rs2   = rs2;
    bus.i_mulctrl_tag   = tag;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 200) begin
      if (bus.o_mulctrl_ready) accepted = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    checkOutput("accept", 128'(accepted), 128'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_mulctrl_valid = 1'b0;
  endtask

  task automatic pushExpected(input logic [XLEN-1:0] result, input logic [TAG_W-1:0] tag);
    exp_q.push_back({result, tag});
  endtask

  // Waits for a result, checks latency, pops the scoreboard and compares
  task automatic collectResult(input string name, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.o_mulctrl_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_valid"}, 128'(bus.o_mulctrl_valid), 128'd1);
    checkOutput({name, "_latency"}, 128'(lat), 128'(exp_lat));
    checkOutput({name, "_sb_depth"}, 128'(exp_q.size()), 128'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput({name, "_result"}, 128'(bus.o_mulctrl_result), 128'(e.result));
      checkOutput({name, "_tag"}, 128'(bus.o_mulctrl_tag), 128'(e.tag));
    end
    if (bus.i_mulctrl_ready) begin
      @(negedge clk);
      checkOutput({name, "_back_idle"}, 128'({bus.o_mulctrl_valid, bus.o_mulctrl_ready}), 128'b01);
    end
  endtask

  initial begin
    int              en_base;
    int              n;
    logic            leak;
    logic            held;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r0;
    logic [TAG_W-1:0] t0;

    assert_count = 0;
    fail_count   = 0;
    en_count     = 0;
    rstn                = 1'b0;
    bus.i_mulctrl_valid = 1'b0;
    bus.i_mulctrl_op    = '0;
    bus.i_mulctrl_rs1   = '0;
    bus.i_mulctrl_rs2   = '0;
    bus.i_mulctrl_tag   = '0;
    bus.i_mulctrl_flush = 1'b0;
    bus.i_mulctrl_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 128'({bus.o_mulctrl_ready, bus.o_mulctrl_valid}), 128'b10);

    $display("[TB] directed multiply cases");
    en_base = en_count;
    applyStimulus(OP_MULHU, '1, '1, 5'd1);
    pushExpected(64'hFFFF_FFFF_FFFF_FFFE, 5'd1);
    collectResult("mulhu_max", 66);
    checkOutput("mulhu_en_once", 128'(en_count - en_base), 128'd1);

    applyStimulus(OP_MUL, -64'sd3, 64'd7, 5'd2);
    pushExpected(64'hFFFF_FFFF_FFFF_FFEB, 5'd2);
    collectResult("mul_neg", 66);

    applyStimulus(OP_MULH, -64'sd3, 64'd7, 5'd3);
    pushExpected(64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
    collectResult("mulh_neg", 66);

    applyStimulus(OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4);
    pushExpected(64'h4000_0000_0000_0000, 5'd4);
    collectResult("mulh_minneg", 66);

    applyStimulus(OP_MULHSU, '1, '1, 5'd5);
    pushExpected(64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
    collectResult("mulhsu", 66);

    $display("[TB] zero fast path");
    en_base = en_count;
    applyStimulus(OP_MULH, -64'sd5, 64'd0, 5'd7);
    pushExpected(64'd0, 5'd7);
    collectResult("zero_rs2", 1);
    checkOutput("zero_no_en", 128'(en_count - en_base), 128'd0);

    $display("[TB] random operands");
    for (int i = 0; i < 3; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      applyStimulus(op, a, b, 5'(13 + i));
      pushExpected(ref_mul(op, a, b), 5'(13 + i));
      collectResult("random", 66);
    end

    $display("[TB] flush while busy");
    applyStimulus(OP_MULHU, '1, '1, 5'd10);
    repeat (11) @(negedge clk);
    bus.i_mulctrl_flush = 1'b1;
    @(negedge clk);
    bus.i_mulctrl_flush = 1'b0;
    leak = 1'b0;
    n    = 0;
    while (n < 100) begin
      leak = leak | bus.o_mulctrl_ready | bus.o_mulctrl_valid;
      if (bus.i_mul_done) break;
      @(negedge clk);
      n++;
    end
    checkOutput("flush_done_seen", 128'(bus.i_mul_done), 128'd1);
    checkOutput("flush_drain_quiet", 128'(leak), 128'd0);
    @(negedge clk);
    checkOutput("flush_back_idle", 128'({bus.o_mulctrl_valid, bus.o_mulctrl_ready}), 128'b01);

    applyStimulus(OP_MUL, 64'd6, 64'd7, 5'd9);
    pushExpected(64'd42, 5'd9);
    collectResult("after_flush", 66);

    $display("[TB] back-pressure");
    bus.i_mulctrl_ready = 1'b0;
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'hFEDC_BA98_7654_3210;
    applyStimulus(OP_MULHU, a, b, 5'd17);
    pushExpected(ref_mul(OP_MULHU, a, b), 5'd17);
    collectResult("backpressure", 66);
    r0 = bus.o_mulctrl_result;
    t0 = bus.o_mulctrl_tag;
    bus.i_mulctrl_valid = 1'b1;
    bus.i_mulctrl_op    = OP_MUL;
    bus.i_mulctrl_rs1   = 64'd1;
    bus.i_mulctrl_rs2   = 64'd1;
    bus.i_mulctrl_tag   = 5'd20;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      held = held && (bus.o_mulctrl_result == r0) && (bus.o_mulctrl_tag == t0)
                  && bus.o_mulctrl_valid && !bus.o_mulctrl_ready;
    end
    checkOutput("backpressure_held", 128'(held), 128'd1);
    checkOutput("backpressure_result", 128'(bus.o_mulctrl_result), 128'(ref_mul(OP_MULHU, a, b)));
    bus.i_mulctrl_valid = 1'b0;
    bus.i_mulctrl_ready = 1'b1;
    @(negedge clk);
    checkOutput("backpressure_release", 128'({bus.o_mulctrl_valid, bus.o_mulctrl_ready}), 128'b01);

    $display("[TB] reset while busy");
    applyStimulus(OP_MULH, 64'd5, 64'd9, 5'd11);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checkAllZero("rst_busy");
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] reset while responding");
    bus.i_mulctrl_ready = 1'b0;
    applyStimulus(OP_MUL, 64'd0, 64'd5, 5'd12);
    checkOutput("resp_before_reset", 128'(bus.o_mulctrl_valid), 128'd1);
    rstn = 1'b0;
    @(negedge clk);
    checkAllZero("rst_resp");
    rstn = 1'b1;
    bus.i_mulctrl_ready = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MULHSU, 64'd0, 64'd3, 5'd21);
    pushExpected(64'd0, 5'd21);
    collectResult("after_reset", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
